fpdiv_ctrl: RTL
===============

Name: fpdiv_ctrl

Overview:
- Control FSM for the Goldschmidt fpdiv datapath. It produces the mux selects and register enables that step one division from start to finish: the sel_mux4/sel_mux3/en_a/en_b/en_rem schedule.
- Accepts a start pulse, sequences the initial-approximation (IA) multiplies, NUM_ITER refinement iterations and the remainder/rounding cycle, then signals done.
- Sits beside fpdiv and drives its control inputs. Operands and rm go straight to fpdiv and do not pass through this block.

Parameters:
- NUM_ITER, 5, refinement iterations after the IA step (legal 1..15).
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > NUM_ITER.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request a division; sampled only in IDLE or DONE
- sel_mux4  output  2  multiplier operand A select: 00 = N, 01 = D, 10 = rega, 11 = regb
- sel_mux3  output  2  multiplier operand B select: 00 = IA, 01 = regc (2-x), 10 = remainder path
- en_a  output  1  load enable for register A (numerator path)
- en_b  output  1  load enable for register B (denominator path)
- en_rem  output  1  load enable for remainder register
- busy  output  1  high from the cycle after start is accepted through the REM cycle
- done  output  1  one-cycle pulse; result registers are valid
- iter  output  CNT_W  current iteration index, for debug/trace

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE and the counter clears.
  - All outputs are 0: sel_mux4=00, sel_mux3=00, en_*=0, busy=0, done=0, iter=0.
- Outputs are a Moore decode of the registered state; there are no combinational start-to-output paths.
- IDLE: all outputs 0. start=1 moves to IA_N; otherwise stay.
- IA_N: sel_mux4=00, sel_mux3=00, en_a=1, busy=1. Always moves to IA_D.
- IA_D: sel_mux4=01, sel_mux3=00, en_b=1, busy=1. Moves to IT_N and sets the counter to 0.
- IT_N: sel_mux4=10, sel_mux3=01, en_a=1, busy=1. Moves to IT_D.
- IT_D: sel_mux4=11, sel_mux3=01, en_b=1, busy=1.
  - If the counter equals NUM_ITER-1, move to REM.
  - Otherwise increment the counter and move to IT_N.
- REM: sel_mux4=10, sel_mux3=10, en_rem=1, en_a=0, en_b=0, busy=1. Moves to DONE.
- DONE: done=1, busy=0, enables 0, sel=00.
  - start=1 moves to IA_N (back-to-back operation).
  - Otherwise move to IDLE.
- Latency: start sampled high at edge k gives IA_N during cycle k+1 and done during cycle k+2*NUM_ITER+4. That is cycle k+14 for the default.
- Exactly one of en_a/en_b/en_rem is high in any busy cycle; never two at once.
- start is ignored in IA_N..REM: no restart, no queuing.
- iter equals the counter value; it holds at NUM_ITER-1 through REM and DONE and clears on the next IA_D.
- Reset mid-operation forces IDLE immediately with all enables low. The partial datapath result is discarded.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package fpdiv_pkg holds:
  - state enum: IDLE, IA_N, IA_D, IT_N, IT_D, REM, DONE;
  - mux4 select constants: SEL4_N, SEL4_D, SEL4_RA, SEL4_RB;
  - mux3 select constants: SEL3_IA, SEL3_RC, SEL3_REM.
- fpdiv imports the same constants.
- No sub-module: a single FSM plus counter.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release with start=0 → all outputs 0, iter=0, remains IDLE for 5 cycles.
- Single op, NUM_ITER=5: start=1 for one cycle →
  - trace mux4/mux3/en_a/en_b/en_rem = 00/00/1/0/0, 01/00/0/1/0, then 5×(10/01/1/0/0, 11/01/0/1/0), then 10/10/0/0/1;
  - done high exactly 14 cycles after the start edge; busy high for 13 cycles.
- Back-to-back: start held at 1 continuously → done pulses every 14 cycles, and a new IA_N follows each DONE with no IDLE cycle.
- start during busy: pulse start at cycles 3 and 9 of an op → trace unchanged, a single done, no second op.
- Reset mid-op: drive reset=0 asynchronously during IT_D of iteration 2 → en_a, en_b, en_rem and busy drop to 0 before the next edge. After release, a fresh start gives a full 14-cycle sequence.
- Integration with fpdiv:
  - Division 0x4F951295 / 0x41E00002 with rm=1 → final_ans matches the manually sequenced run bit for bit, and matches the f32_div_rne vector.
  - NUM_ITER=1 build → done 6 cycles after start.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared encodings for the Goldschmidt divider: controller states and the
// operand-mux select codes used by both fpdiv_ctrl and the fpdiv datapath.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IA_N = 3'd1,
    IA_D = 3'd2,
    IT_N = 3'd3,
    IT_D = 3'd4,
    REM  = 3'd5,
    DONE = 3'd6
  } state_e;

  localparam logic [1:0] SEL4_N   = 2'b00;
  localparam logic [1:0] SEL4_D   = 2'b01;
  localparam logic [1:0] SEL4_RA  = 2'b10;
  localparam logic [1:0] SEL4_RB  = 2'b11;

  localparam logic [1:0] SEL3_IA  = 2'b00;
  localparam logic [1:0] SEL3_RC  = 2'b01;
  localparam logic [1:0] SEL3_REM = 2'b10;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Sequencer for one Goldschmidt division: IA multiplies, NUM_ITER N/D
// refinement pairs, a remainder cycle, then a one-cycle done pulse.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int NUM_ITER = 5,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [1:0]       sel_mux4,
  output logic [1:0]       sel_mux3,
  output logic             en_a,
  output logic             en_b,
  output logic             en_rem,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ITER - 1);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Counter is cleared leaving IA_D and holds its last value through REM/DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_cnt <= '0;
    else if (r_state == IA_D)                  r_cnt <= '0;
    else if (r_state == IT_D && r_cnt != LAST) r_cnt <= r_cnt + CNT_W'(1);
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? IA_N : IDLE;
      IA_N:    w_next = IA_D;
      IA_D:    w_next = IT_N;
      IT_N:    w_next = IT_D;
      IT_D:    w_next = (r_cnt == LAST) ? REM : IT_N;
      REM:     w_next = DONE;
      DONE:    w_next = start ? IA_N : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    sel_mux4 = SEL4_N;
    sel_mux3 = SEL3_IA;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_rem   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IA_N: begin
        en_a = 1'b1;
        busy = 1'b1;
      end
      IA_D: begin
        sel_mux4 = SEL4_D;
        en_b     = 1'b1;
        busy     = 1'b1;
      end
      IT_N: begin
        sel_mux4 = SEL4_RA;
        sel_mux3 = SEL3_RC;
        en_a     = 1'b1;
        busy     = 1'b1;
      end
      IT_D: begin
        sel_mux4 = SEL4_RB;
        sel_mux3 = SEL3_RC;
        en_b     = 1'b1;
        busy     = 1'b1;
      end
      REM: begin
        sel_mux4 = SEL4_RA;
        sel_mux3 = SEL3_REM;
        en_rem   = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign iter = r_cnt;

endmodule
